// File: rtl/data_sram_if.sv
// Data-SRAM request/response bundle between the CPU data path (master)
// and the memory-side responder (slave).
interface data_sram_if;
    logic        en;
    logic [3:0]  wen;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        ready;
    logic        rvalid;
    logic [31:0] rdata;
    logic        wdone;

    modport master (
        output en, wen, addr, wdata,
        input  ready, rvalid, rdata, wdone
    );

    modport slave (
        input  en, wen, addr, wdata,
        output ready, rvalid, rdata, wdone
    );
endinterface

// File: rtl/data_sram_responder.sv
// Memory-side responder for the CPU data-SRAM interface. Requests are queued
// in arrival order and serviced one at a time after a fixed number of busy
// cycles against an internal byte-lane word RAM. Reads return a one-cycle
// rvalid pulse with data; writes return a one-cycle wdone pulse and commit
// their enabled byte lanes as the access leaves DONE.
module data_sram_responder #(
    parameter int ADDR_W     = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int LATENCY    = 3
) (
    input  logic       clk,
    input  logic       resetn,
    data_sram_if.slave data_sram
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam int WORDS = 2 ** ADDR_W;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t             state_reg, state_next;
    logic [CNT_W-1:0]   cnt_reg, cnt_next;

    logic [PTR_W-1:0]   head_reg, tail_reg;
    logic [PTR_W:0]     count_reg;

    // Request queue storage; only the word index of the address is kept.
    logic [3:0]         q_wen   [FIFO_DEPTH];
    logic [ADDR_W-1:0]  q_word  [FIFO_DEPTH];
    logic [31:0]        q_wdata [FIFO_DEPTH];

    logic               ready_int;
    logic               push;
    logic               pop;
    logic [3:0]         head_wen;
    logic [ADDR_W-1:0]  head_word;
    logic [31:0]        head_wdata;
    logic               head_is_read;
    logic               ram_we;
    logic [31:0]        ram_rdata;
    logic               rvalid_int;
    logic               wdone_int;

    // Byte offset and high address bits do not select a word; the RAM aliases.
    logic               unused_addr_bits;
    assign unused_addr_bits = ^{data_sram.addr[31:ADDR_W+2], data_sram.addr[1:0]};

    // A slot freed by this cycle's pop is not offered to this cycle's requester.
    assign ready_int = (count_reg != (PTR_W+1)'(FIFO_DEPTH));
    assign push      = data_sram.en && ready_int;
    assign pop       = (state_reg == ST_DONE);

    assign head_wen     = q_wen[head_reg];
    assign head_word    = q_word[head_reg];
    assign head_wdata   = q_wdata[head_reg];
    assign head_is_read = (head_wen == 4'h0);

    // Write lanes commit on the DONE->IDLE edge; a reset forces IDLE, so an
    // interrupted access never reaches the RAM.
    assign ram_we     = (state_reg == ST_DONE) && !head_is_read;
    assign rvalid_int = (state_reg == ST_DONE) && head_is_read;
    assign wdone_int  = (state_reg == ST_DONE) && !head_is_read;

    // Queue payload capture at the tail slot.
    always_ff @(posedge clk) begin
        if (push) begin
            q_wen[tail_reg]   <= data_sram.wen;
            q_word[tail_reg]  <= data_sram.addr[ADDR_W+1:2];
            q_wdata[tail_reg] <= data_sram.wdata;
        end
    end

    // Queue pointers and occupancy; push and pop in one cycle leave count unchanged.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            head_reg  <= '0;
            tail_reg  <= '0;
            count_reg <= '0;
        end else begin
            if (push) begin
                tail_reg <= tail_reg + PTR_W'(1);
            end
            if (pop) begin
                head_reg <= head_reg + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_reg <= count_reg + (PTR_W+1)'(1);
                2'b01:   count_reg <= count_reg - (PTR_W+1)'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

    // Access sequencer state and busy-cycle counter.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_reg <= ST_IDLE;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    // Next-state: start on a non-empty queue, count down busy cycles, then retire.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            ST_IDLE: begin
                if (count_reg != '0) begin
                    state_next = ST_BUSY;
                    cnt_next   = CNT_W'(LATENCY - 1);
                end
            end
            ST_BUSY: begin
                if (cnt_reg == '0) begin
                    state_next = ST_DONE;
                end else begin
                    cnt_next = cnt_reg - CNT_W'(1);
                end
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    // One RAM per byte lane. The read port is registered every cycle at the
    // head word; the head is stable through BUSY, so the value is settled by
    // DONE, and any earlier write to that word has already committed.
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        logic [7:0] mem [WORDS];
        logic [7:0] rd_q;

        // Byte-lane write on commit and registered read of the head word.
        always_ff @(posedge clk) begin
            if (ram_we && head_wen[gi]) begin
                mem[head_word] <= head_wdata[gi*8 +: 8];
            end
            rd_q <= mem[head_word];
        end

        assign ram_rdata[gi*8 +: 8] = rd_q;
    end

    assign data_sram.ready  = ready_int;
    assign data_sram.rvalid = rvalid_int;
    assign data_sram.wdone  = wdone_int;
    assign data_sram.rdata  = rvalid_int ? ram_rdata : 32'h0;

endmodule
